// File: rtl/seq_data_memory.sv
// Y86-64 SEQ data-memory stage: synchronous word-indexed stores, combinational loads.
// Optional macro DMEM_ERR_EN enables out-of-range detection; otherwise addresses wrap modulo MEM_WORDS.
module seq_data_memory #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  icode,
  input  logic [63:0] valA,
  input  logic [63:0] valB,
  input  logic [63:0] valE,
  input  logic [63:0] valP,
  output logic [63:0] valM,
  output logic        dmem_error
);

  localparam int MEM_WORDS = 2 ** ADDR_W;

  logic [63:0]       mem_r [MEM_WORDS];
  logic              wr_en_s;
  logic              rd_en_s;
  logic [63:0]       addr_s;
  logic [63:0]       wdata_s;
  logic [ADDR_W-1:0] idx_s;
  logic              wr_ok_s;
  logic              rd_ok_s;
  logic              err_s;

  // Decode icode into access type, address source and store data
  always_comb begin
    wr_en_s = 1'b0;
    rd_en_s = 1'b0;
    addr_s  = 64'd0;
    wdata_s = 64'd0;
    case (icode)
      4'h4, 4'hA: begin
        wr_en_s = 1'b1;
        addr_s  = valE;
        wdata_s = valA;
      end
      4'h8: begin
        wr_en_s = 1'b1;
        addr_s  = valE;
        wdata_s = valP;
      end
      4'h5: begin
        rd_en_s = 1'b1;
        addr_s  = valE;
      end
      4'h9, 4'hB: begin
        rd_en_s = 1'b1;
        addr_s  = valB;
      end
      default: begin
        wr_en_s = 1'b0;
        rd_en_s = 1'b0;
      end
    endcase
  end

  assign idx_s = addr_s[ADDR_W-1:0];

`ifdef DMEM_ERR_EN
  logic oor_s;
  assign oor_s   = |addr_s[63:ADDR_W];
  assign wr_ok_s = wr_en_s & ~oor_s;
  assign rd_ok_s = rd_en_s & ~oor_s;
  assign err_s   = (wr_en_s | rd_en_s) & oor_s;
`else
  // Upper address bits are deliberately discarded: accesses wrap modulo MEM_WORDS.
  logic unused_hi_s;
  assign unused_hi_s = ^addr_s[63:ADDR_W];
  assign wr_ok_s     = wr_en_s;
  assign rd_ok_s     = rd_en_s;
  assign err_s       = 1'b0;
`endif

  // Combinational load path, forced quiet while reset is held
  always_comb begin
    valM       = 64'd0;
    dmem_error = 1'b0;
    if (rst_n) begin
      if (rd_ok_s) begin
        valM = mem_r[idx_s];
      end else begin
        valM = 64'd0;
      end
      dmem_error = err_s;
    end else begin
      valM       = 64'd0;
      dmem_error = 1'b0;
    end
  end

  // Memory array: whole-array clear on reset, otherwise at most one store per edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_WORDS; i++) begin
        mem_r[i] <= 64'd0;
      end
    end else if (wr_ok_s) begin
      mem_r[idx_s] <= wdata_s;
    end
  end

endmodule

// File: tb/tb_seq_data_memory.sv
// Scoreboard bench for seq_data_memory: directed plan then randomized ops vs. an array model.
// Honours DMEM_ERR_EN the same way the design does.
module tb_seq_data_memory;

  localparam int      AW = 10;
  localparam longint  MW = 64'd1 << AW;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  icode = 4'd0;
  logic [63:0] valA = 64'd0;
  logic [63:0] valB = 64'd0;
  logic [63:0] valE = 64'd0;
  logic [63:0] valP = 64'd0;
  logic [63:0] valM;
  logic        dmem_error;

  typedef struct {
    logic [63:0] m;
    logic        e;
    int          id;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] model [int];
  int          checks = 0;
  int          errors = 0;
  int          op_id = 0;

`ifdef DMEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  seq_data_memory #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .icode(icode), .valA(valA), .valB(valB),
    .valE(valE), .valP(valP), .valM(valM), .dmem_error(dmem_error)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rd_model(input longint unsigned idx);
    if (model.exists(int'(idx))) return model[int'(idx)];
    return 64'd0;
  endfunction

  // Drive one operation for one cycle and push its expected response.
  task automatic cyc(input logic rst, input logic [3:0] ic, input logic [63:0] a,
                     input logic [63:0] b, input logic [63:0] e, input logic [63:0] p,
                     input bit use_c, input logic [63:0] cm, input logic ce);
    bit          wr, rd, oor;
    logic [63:0] addr, wd, xm;
    logic        xe;
    exp_t        it;
    @(posedge clk);
    #1;
    rst_n = rst; icode = ic; valA = a; valB = b; valE = e; valP = p;
    wr   = (ic == 4'h4) || (ic == 4'hA) || (ic == 4'h8);
    rd   = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
    addr = ((ic == 4'h9) || (ic == 4'hB)) ? b : e;
    wd   = (ic == 4'h8) ? p : a;
    oor  = (addr / MW) != 64'd0;
    xm = 64'd0;
    xe = 1'b0;
    if (rst) begin
      if (ERR_EN && oor) xe = wr || rd;
      if (rd && !(ERR_EN && oor)) xm = rd_model(addr % MW);
    end
    it.m  = use_c ? cm : xm;
    it.e  = use_c ? ce : xe;
    it.id = op_id;
    op_id++;
    sb_q.push_back(it);
    if (!rst) model.delete();
    else if (wr && !(ERR_EN && oor)) model[int'(addr % MW)] = wd;
  endtask

  // Monitor: compare mid-cycle against the oldest expected entry.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        checks++;
        if (valM !== x.m) begin
          errors++;
          $display("FAIL valM op %0d: got %h expected %h", x.id, valM, x.m);
        end
        checks++;
        if (dmem_error !== x.e) begin
          errors++;
          $display("FAIL dmem_error op %0d: got %b expected %b", x.id, dmem_error, x.e);
        end
      end
    end
  end

  initial begin
    logic [63:0] ad, r;
    cyc(1'b0, 4'h5, 64'd0, 64'd0, 64'd7, 64'd0, 1'b1, 64'd0, 1'b0);
    cyc(1'b0, 4'h4, 64'd9, 64'd0, 64'd7, 64'd0, 1'b1, 64'd0, 1'b0);
    cyc(1'b1, 4'h5, 64'd0, 64'd0, 64'd7, 64'd0, 1'b1, 64'd0, 1'b0);
    cyc(1'b1, 4'h4, 64'd4, 64'd0, 64'd1, 64'd0, 1'b1, 64'd0, 1'b0);
    cyc(1'b1, 4'h5, 64'd0, 64'd0, 64'd1, 64'd0, 1'b1, 64'd4, 1'b0);
    cyc(1'b1, 4'hA, 64'd8, 64'd0, 64'd2, 64'd0, 1'b1, 64'd0, 1'b0);
    cyc(1'b1, 4'hB, 64'd0, 64'd2, 64'd0, 64'd0, 1'b1, 64'd8, 1'b0);
    cyc(1'b1, 4'h5, 64'd0, 64'd0, 64'd1, 64'd0, 1'b1, 64'd4, 1'b0);
    cyc(1'b1, 4'h8, 64'd0, 64'd0, 64'd3, 64'd20, 1'b1, 64'd0, 1'b0);
    cyc(1'b1, 4'h9, 64'd0, 64'd3, 64'd0, 64'd0, 1'b1, 64'd20, 1'b0);
    cyc(1'b1, 4'h0, 64'd99, 64'd3, 64'd3, 64'd99, 1'b1, 64'd0, 1'b0);
    cyc(1'b1, 4'h9, 64'd0, 64'd3, 64'd0, 64'd0, 1'b1, 64'd20, 1'b0);
    cyc(1'b1, 4'h4, 64'h55, 64'd0, MW + 64'd1, 64'd0, 1'b1, 64'd0, ERR_EN);
    cyc(1'b1, 4'h5, 64'd0, 64'd0, 64'd1, 64'd0, 1'b1, ERR_EN ? 64'd4 : 64'h55, 1'b0);
    cyc(1'b1, 4'hB, 64'd0, MW + 64'd2, 64'd0, 64'd0, 1'b1, ERR_EN ? 64'd0 : 64'd8, ERR_EN);
    cyc(1'b0, 4'h5, 64'd0, 64'd0, 64'd1, 64'd0, 1'b1, 64'd0, 1'b0);
    cyc(1'b1, 4'hB, 64'd0, 64'd2, 64'd0, 64'd0, 1'b1, 64'd0, 1'b0);
    cyc(1'b1, 4'h5, 64'd0, 64'd0, 64'd1, 64'd0, 1'b1, 64'd0, 1'b0);
    for (int n = 0; n < 600; n++) begin
      r = 64'($urandom_range(0, 9));
      if (r < 64'd8) ad = 64'($urandom_range(0, 15));
      else if (r == 64'd8) ad = MW + 64'($urandom_range(0, 15));
      else ad = {32'($urandom), 32'($urandom)};
      cyc(($urandom_range(0, 49) != 0), 4'($urandom_range(0, 15)),
          {32'($urandom), 32'($urandom)}, ad, ad, {32'($urandom), 32'($urandom)},
          1'b0, 64'd0, 1'b0);
    end
    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge clk);
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_data_memory.md
Name: seq_data_memory

Overview:
- Data-memory stage of the single-cycle (SEQ) Y86-64 processor; sits between execute and write-back.
- Decodes icode to perform one 64-bit store or load per cycle.
- Stores are synchronous; loads are combinational, so valM is valid in the same cycle for the write-back stage.

Parameters:
- ADDR_W, 10, word-address width; memory depth MEM_WORDS = 2**ADDR_W 64-bit words.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- icode  input  4  Y86 instruction code of the current instruction.
- valA  input  64  store data for rmmovq/pushq.
- valB  input  64  address source for popq/ret (stack pointer).
- valE  input  64  address for rmmovq/mrmovq/pushq/call (ALU result).
- valP  input  64  return address stored by call.
- valM  output  64  load data.
- dmem_error  output  1  out-of-range access flag.

Behaviour:
- Storage: MEM_WORDS x 64-bit array; addressing is word-indexed (address N selects word N, not byte N). Data width is fixed at 64.
- icode decode:
  - 4 rmmovq: write valA to mem[valE].
  - 5 mrmovq: read mem[valE].
  - A pushq: write valA to mem[valE].
  - 8 call: write valP to mem[valE].
  - B popq: read mem[valB].
  - 9 ret: read mem[valB].
  - All other codes: no access; valM = 0; dmem_error = 0.
- Writes: take effect on the rising clk edge while the write icode is present. At most one write per cycle.
- Reads: combinational; valM = mem[addr] whenever a read icode is present.
  - A read of a word written on the preceding edge returns the new value.
  - No same-cycle forwarding of a pending write is required.
- Out-of-range: an address is out of range when any bit above ADDR_W-1 is set. Handling is governed by DMEM_ERR_EN.
- Reset:
  - On a rising edge with rst_n=0, every memory word is cleared to 0 in that single cycle and any write that cycle is suppressed.
  - While rst_n=0, valM = 0 and dmem_error = 0 combinationally.
  - Reset asserted mid-sequence discards all prior contents.
- Post-reset, before any write: all reads return 0.
- No handshake; one operation per cycle; latency is 1 edge for writes and 0 cycles for reads.

Optional Feature:
- Macro: DMEM_ERR_EN.
- Defined:
  - An out-of-range access on a read or write icode drives dmem_error=1 combinationally.
  - An out-of-range write is suppressed and memory is unchanged.
  - An out-of-range read returns valM=0.
- Undefined:
  - dmem_error is tied to 0.
  - Addresses are truncated to the low ADDR_W bits (wrap modulo MEM_WORDS) for both reads and writes.

Test Plan:
- Reset: hold rst_n=0 for 2 edges, release; icode=5, valE=7 -> valM=0, dmem_error=0.
- rmmovq/mrmovq: icode=4, valA=4, valE=1, one edge; then icode=5, valE=1 -> valM=4.
- pushq/popq: icode=A, valA=8, valE=2, edge; then icode=B, valB=2 -> valM=8. Word 1 still reads 4 (no overlap between adjacent words).
- call/ret: icode=8, valP=20, valE=3, edge; then icode=9, valB=3 -> valM=20. Also icode=0 (halt) -> valM=0 and no write occurs.
- Range with DMEM_ERR_EN defined: icode=4, valA=0x55, valE=MEM_WORDS+1, edge -> dmem_error=1 during the cycle; icode=5, valE=1 -> valM=4 (unchanged).
- Range with DMEM_ERR_EN undefined: the same store writes word 1 (wrap); icode=5, valE=1 -> valM=0x55; dmem_error=0.
